// File: rtl/led_ram_arbiter_pkg.sv
// Shared LED-matrix parameters and the arbiter state encoding.
// Contents:
//   LED_ROWS / LED_COLS      - matrix geometry (8x8)
//   FILL_WORDS               - number of display-RAM words covered by a bulk fill
//   DEFAULT_SCAN_MAX_WAIT    - default scan starvation limit
//   arb_state_t              - IDLE / SERVE / FILL arbiter states
package led_ram_arbiter_pkg;

  localparam int LED_ROWS              = 8;
  localparam int LED_COLS              = 8;
  localparam int FILL_WORDS            = LED_ROWS * LED_COLS;
  localparam int DEFAULT_SCAN_MAX_WAIT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    FILL  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/led_ram_arbiter_fill.sv
// ram_fill_engine: walks the display RAM from address 0 to the last word,
// writing one fill word per cycle, then pulses done once.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - begin a fill (ignored while busy)
//   data       - fill word, captured when start is accepted
//   addr, we   - current write address and write enable
//   wdata      - captured fill word
//   busy       - high for every write cycle of the fill
//   done       - one-cycle pulse in the cycle after the final write
module ram_fill_engine
  import led_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FILL_WORDS - 1);

  logic [ADDR_W-1:0] count;
  logic [DATA_W-1:0] fill_word;

  // The counter stops on the last address instead of wrapping, so a late
  // look at addr after the fill never shows a bogus address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      fill_word <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (count == LAST_ADDR) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end else if (start) begin
        busy      <= 1'b1;
        count     <= '0;
        fill_word <= data;
      end
    end
  end

  assign addr  = count;
  assign we    = busy;
  assign wdata = fill_word;

endmodule

// File: rtl/led_ram_arbiter.sv
// led_ram_arbiter: shares one single-port display RAM between the light-pen
// writer, the scan-driver reader and a bulk fill engine.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   pen_req/pen_addr/pen_data      - pen write request (held until pen_gnt)
//   pen_gnt                        - pen write issued this cycle
//   scan_req/scan_addr             - scan read request
//   scan_gnt                       - scan read issued this cycle
//   scan_valid/scan_rdata          - read data, one cycle after scan_gnt
//   clr_start/clr_data             - start a whole-RAM fill with clr_data
//   clr_busy/clr_done              - fill running / one-cycle completion
//   ram_we/ram_addr/ram_wdata      - RAM control
//   ram_rdata                      - RAM read data (one-cycle latency)
//   last_row/last_col              - position of the most recent pen write
module led_ram_arbiter
  import led_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 6,
  parameter int DATA_W        = 4,
  parameter int SCAN_MAX_WAIT = DEFAULT_SCAN_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pen_req,
  input  logic [ADDR_W-1:0] pen_addr,
  input  logic [DATA_W-1:0] pen_data,
  output logic              pen_gnt,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_gnt,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [2:0]        last_row,
  output logic [2:0]        last_col
);

  localparam int                WAIT_W     = (SCAN_MAX_WAIT < 1) ? 1 : $clog2(SCAN_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(SCAN_MAX_WAIT);
  localparam logic [ADDR_W-1:0] FILL_LAST  = ADDR_W'(FILL_WORDS - 1);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [WAIT_W-1:0] scan_wait;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic              arb_enable;
  logic              scan_forced;
  logic              fill_start;
  logic              fill_we;
  logic              fill_busy;
  logic              fill_done;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_wdata;

  // Grants are combinational so the access reaches the RAM in the request
  // cycle. Gating with rst_n keeps every output low while reset is held,
  // even though the requests themselves are live inputs.
  always_comb begin
    arb_enable  = rst_n && (state != FILL);
    scan_forced = scan_req && (scan_wait == WAIT_LIMIT);
    pen_gnt     = arb_enable && pen_req && !scan_forced;
    scan_gnt    = arb_enable && scan_req && (scan_forced || !pen_req);
    fill_start  = arb_enable && clr_start;
  end

  // RAM port mux; with no access the address and write data keep their
  // previous values so the RAM pins do not toggle needlessly.
  always_comb begin
    ram_we    = pen_gnt || fill_we;
    ram_addr  = hold_addr;
    ram_wdata = hold_wdata;
    if (pen_gnt) begin
      ram_addr  = pen_addr;
      ram_wdata = pen_data;
    end else if (scan_gnt) begin
      ram_addr  = scan_addr;
    end else if (fill_we) begin
      ram_addr  = fill_addr;
      ram_wdata = fill_wdata;
    end
  end

  // Next-state logic: a fill request wins the next cycle outright; FILL
  // ends after the last fill write so the done cycle already arbitrates.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, SERVE: begin
        if (fill_start) begin
          state_next = FILL;
        end else if (pen_gnt || scan_gnt) begin
          state_next = SERVE;
        end else begin
          state_next = IDLE;
        end
      end
      FILL: begin
        if (fill_we && (fill_addr == FILL_LAST)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Starvation counter for the scan port: it only counts cycles in which
  // the scan actually lost to the pen, never the fill cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_wait <= '0;
    end else if (scan_gnt) begin
      scan_wait <= '0;
    end else if ((state != FILL) && scan_req && (scan_wait != WAIT_LIMIT)) begin
      scan_wait <= scan_wait + 1'b1;
    end
  end

  // Hold registers, read-return flag and the pen position tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_addr  <= '0;
      hold_wdata <= '0;
      scan_valid <= 1'b0;
      last_row   <= '0;
      last_col   <= '0;
    end else begin
      hold_addr  <= ram_addr;
      hold_wdata <= ram_wdata;
      scan_valid <= scan_gnt;
      if (pen_gnt) begin
        last_row <= pen_addr[5:3];
        last_col <= pen_addr[2:0];
      end
    end
  end

  assign scan_rdata = scan_valid ? ram_rdata : '0;
  assign clr_busy   = fill_busy;
  assign clr_done   = fill_done;

  ram_fill_engine #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fill (
    .clk  (clk),
    .rst_n(rst_n),
    .start(fill_start),
    .data (clr_data),
    .addr (fill_addr),
    .we   (fill_we),
    .wdata(fill_wdata),
    .busy (fill_busy),
    .done (fill_done)
  );

endmodule

// File: tb/tb_led_ram_arbiter.sv
// Testbench for led_ram_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked each cycle against a
// behavioural model of the arbiter and a model copy of the display RAM.
module tb_led_ram_arbiter;

  localparam int SCAN_MAX_WAIT = 3;
  localparam int FILL_WORDS    = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pen_req = 1'b0;
  logic [5:0] pen_addr = '0;
  logic [3:0] pen_data = '0;
  logic       pen_gnt;
  logic       scan_req = 1'b0;
  logic [5:0] scan_addr = '0;
  logic       scan_gnt;
  logic       scan_valid;
  logic [3:0] scan_rdata;
  logic       clr_start = 1'b0;
  logic [3:0] clr_data = '0;
  logic       clr_busy;
  logic       clr_done;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata = '0;
  logic [2:0] last_row;
  logic [2:0] last_col;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  led_ram_arbiter #(
    .ADDR_W(6),
    .DATA_W(4),
    .SCAN_MAX_WAIT(SCAN_MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pen_req   (pen_req),
    .pen_addr  (pen_addr),
    .pen_data  (pen_data),
    .pen_gnt   (pen_gnt),
    .scan_req  (scan_req),
    .scan_addr (scan_addr),
    .scan_gnt  (scan_gnt),
    .scan_valid(scan_valid),
    .scan_rdata(scan_rdata),
    .clr_start (clr_start),
    .clr_data  (clr_data),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .last_row  (last_row),
    .last_col  (last_col)
  );

  // Display RAM seen by the DUT: synchronous write, one-cycle read latency.
  logic [3:0] ram_mem [FILL_WORDS] = '{default: 4'h0};

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Behavioural model: remaining fill words, scan starvation count, the
  // pending read value and a model copy of the RAM contents.
  logic [3:0] model_mem [FILL_WORDS] = '{default: 4'h0};
  int         m_wait = 0;
  int         m_fill_left = 0;
  logic [3:0] m_fill_word = '0;
  logic       m_done_now = 1'b0;
  logic       m_valid_now = 1'b0;
  logic [3:0] m_read_data = '0;
  logic [5:0] m_hold_addr = '0;
  logic [3:0] m_hold_wdata = '0;
  logic [2:0] m_last_row = '0;
  logic [2:0] m_last_col = '0;
  logic       m_filling, m_forced, e_pen, e_scan, e_we;
  logic [5:0] e_addr;
  logic [3:0] e_wdata;

  // Compare on the falling edge: inputs change just after the rising edge,
  // so both DUT outputs and inputs are settled here.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst pen_gnt",    32'(pen_gnt),    32'd0);
      checkOutput("rst scan_gnt",   32'(scan_gnt),   32'd0);
      checkOutput("rst scan_valid", 32'(scan_valid), 32'd0);
      checkOutput("rst scan_rdata", 32'(scan_rdata), 32'd0);
      checkOutput("rst clr_busy",   32'(clr_busy),   32'd0);
      checkOutput("rst clr_done",   32'(clr_done),   32'd0);
      checkOutput("rst ram_we",     32'(ram_we),     32'd0);
      checkOutput("rst ram_addr",   32'(ram_addr),   32'd0);
      checkOutput("rst ram_wdata",  32'(ram_wdata),  32'd0);
      checkOutput("rst last_row",   32'(last_row),   32'd0);
      checkOutput("rst last_col",   32'(last_col),   32'd0);
      m_wait       = 0;
      m_fill_left  = 0;
      m_done_now   = 1'b0;
      m_valid_now  = 1'b0;
      m_read_data  = '0;
      m_hold_addr  = '0;
      m_hold_wdata = '0;
      m_last_row   = '0;
      m_last_col   = '0;
    end else begin
      m_filling = (m_fill_left > 0);
      m_forced  = scan_req && (m_wait == SCAN_MAX_WAIT);
      e_pen     = !m_filling && pen_req && !m_forced;
      e_scan    = !m_filling && scan_req && (m_forced || !pen_req);
      e_we      = e_pen || m_filling;
      e_addr    = m_hold_addr;
      e_wdata   = m_hold_wdata;
      if (e_pen) begin
        e_addr  = pen_addr;
        e_wdata = pen_data;
      end else if (e_scan) begin
        e_addr  = scan_addr;
      end else if (m_filling) begin
        e_addr  = 6'(FILL_WORDS - m_fill_left);
        e_wdata = m_fill_word;
      end

      checkOutput("pen_gnt",    32'(pen_gnt),    32'(e_pen));
      checkOutput("scan_gnt",   32'(scan_gnt),   32'(e_scan));
      checkOutput("ram_we",     32'(ram_we),     32'(e_we));
      checkOutput("ram_addr",   32'(ram_addr),   32'(e_addr));
      checkOutput("ram_wdata",  32'(ram_wdata),  32'(e_wdata));
      checkOutput("clr_busy",   32'(clr_busy),   32'(m_filling));
      checkOutput("clr_done",   32'(clr_done),   32'(m_done_now));
      checkOutput("scan_valid", 32'(scan_valid), 32'(m_valid_now));
      if (m_valid_now) checkOutput("scan_rdata", 32'(scan_rdata), 32'(m_read_data));
      checkOutput("last_row",   32'(last_row),   32'(m_last_row));
      checkOutput("last_col",   32'(last_col),   32'(m_last_col));

      if (e_we) model_mem[e_addr] = e_wdata;
      m_hold_addr  = e_addr;
      m_hold_wdata = e_wdata;
      m_valid_now  = e_scan;
      if (e_scan) m_read_data = model_mem[scan_addr];
      if (e_pen) begin
        m_last_row = pen_addr[5:3];
        m_last_col = pen_addr[2:0];
      end
      if (e_scan) m_wait = 0;
      else if (!m_filling && scan_req && (m_wait < SCAN_MAX_WAIT)) m_wait++;
      m_done_now = m_filling && (m_fill_left == 1);
      if (m_filling) begin
        m_fill_left--;
      end else if (clr_start) begin
        m_fill_left = FILL_WORDS;
        m_fill_word = clr_data;
      end
    end
  end

  // Drives one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic pr, input logic [5:0] pa, input logic [3:0] pd,
                               input logic sr, input logic [5:0] sa,
                               input logic cs, input logic [3:0] cd);
    @(posedge clk);
    #1;
    pen_req   = pr;
    pen_addr  = pa;
    pen_data  = pd;
    scan_req  = sr;
    scan_addr = sa;
    clr_start = cs;
    clr_data  = cd;
  endtask

  int         busy_cnt, we_cnt, pen_cnt, done_cnt;
  logic       pen_taken, scan_taken;
  logic [3:0] exp_word;

  initial begin
    // Reset held with live requests: every output must stay low.
    repeat (3) applyStimulus(1'b1, 6'd9, 4'hF, 1'b1, 6'd2, 1'b1, 4'h3);
    #2;
    checkOutput("lit reset pen_gnt", 32'(pen_gnt), 32'd0);
    checkOutput("lit reset ram_we",  32'(ram_we),  32'd0);
    applyStimulus(1'b0, 6'd0, 4'h0, 1'b0, 6'd0, 1'b0, 4'h0);
    rst_n = 1'b1;

    // Pen write then scan read-back of the same location.
    applyStimulus(1'b1, 6'b101_011, 4'b1010, 1'b0, 6'd0, 1'b0, 4'h0);
    #2;
    checkOutput("lit pen_gnt",  32'(pen_gnt),  32'd1);
    checkOutput("lit pen we",   32'(ram_we),   32'd1);
    checkOutput("lit pen addr", 32'(ram_addr), 32'd43);
    applyStimulus(1'b0, 6'd0, 4'h0, 1'b1, 6'b101_011, 1'b0, 4'h0);
    #2;
    checkOutput("lit last_row", 32'(last_row), 32'd5);
    checkOutput("lit last_col", 32'(last_col), 32'd3);
    checkOutput("lit scan_gnt", 32'(scan_gnt), 32'd1);
    checkOutput("lit scan we",  32'(ram_we),   32'd0);
    applyStimulus(1'b0, 6'd0, 4'h0, 1'b0, 6'd0, 1'b0, 4'h0);
    #2;
    checkOutput("lit scan_valid", 32'(scan_valid), 32'd1);
    checkOutput("lit scan_rdata", 32'(scan_rdata), 32'hA);

    // Both requesters busy: pen, pen, pen, scan, repeating.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 6'd12, 4'h4, 1'b1, 6'd13, 1'b0, 4'h0);
      #2;
      checkOutput("lit starve scan_gnt", 32'(scan_gnt), 32'((i % 4) == 3));
      checkOutput("lit starve pen_gnt",  32'(pen_gnt),  32'((i % 4) != 3));
    end

    // Bulk fill with the pen held throughout and a second start ignored.
    applyStimulus(1'b0, 6'd0, 4'h0, 1'b0, 6'd0, 1'b1, 4'b1000);
    busy_cnt = 0; we_cnt = 0; pen_cnt = 0; done_cnt = 0;
    for (int i = 0; i < FILL_WORDS; i++) begin
      applyStimulus(1'b1, 6'd7, 4'b0101, 1'b0, 6'd0, (i == 9), 4'b0110);
      #2;
      checkOutput("lit fill addr", 32'(ram_addr), 32'(i));
      busy_cnt += 32'(clr_busy);
      we_cnt   += 32'(ram_we);
      pen_cnt  += 32'(pen_gnt);
      done_cnt += 32'(clr_done);
    end
    checkOutput("lit fill busy cycles", 32'(busy_cnt), 32'd64);
    checkOutput("lit fill writes",      32'(we_cnt),   32'd64);
    checkOutput("lit fill pen grants",  32'(pen_cnt),  32'd0);
    applyStimulus(1'b1, 6'd7, 4'b0101, 1'b0, 6'd0, 1'b0, 4'h0);
    #2;
    done_cnt += 32'(clr_done);
    checkOutput("lit fill clr_done",   32'(clr_done), 32'd1);
    checkOutput("lit post-fill pen",   32'(pen_gnt),  32'd1);
    checkOutput("lit post-fill busy",  32'(clr_busy), 32'd0);
    checkOutput("lit fill done count", 32'(done_cnt), 32'd1);

    // Read every word back.
    for (int a = 0; a < FILL_WORDS; a++) begin
      applyStimulus(1'b0, 6'd0, 4'h0, 1'b1, 6'(a), 1'b0, 4'h0);
      applyStimulus(1'b0, 6'd0, 4'h0, 1'b0, 6'd0, 1'b0, 4'h0);
      #2;
      exp_word = (a == 7) ? 4'b0101 : 4'b1000;
      checkOutput("lit readback", 32'(scan_rdata), 32'(exp_word));
    end

    // Reset in the middle of a fill, at fill address 20.
    applyStimulus(1'b0, 6'd0, 4'h0, 1'b0, 6'd0, 1'b1, 4'b0011);
    repeat (21) applyStimulus(1'b0, 6'd0, 4'h0, 1'b0, 6'd0, 1'b0, 4'h0);
    #2;
    checkOutput("lit abort addr", 32'(ram_addr), 32'd20);
    checkOutput("lit abort busy", 32'(clr_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("lit abort we",    32'(ram_we),   32'd0);
    checkOutput("lit abort busy0", 32'(clr_busy), 32'd0);
    checkOutput("lit abort addr0", 32'(ram_addr), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    we_cnt = 0; done_cnt = 0;
    repeat (70) begin
      applyStimulus(1'b0, 6'd0, 4'h0, 1'b0, 6'd0, 1'b0, 4'h0);
      #2;
      we_cnt   += 32'(ram_we);
      done_cnt += 32'(clr_done);
    end
    checkOutput("lit abort writes", 32'(we_cnt),   32'd0);
    checkOutput("lit abort done",   32'(done_cnt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      logic [5:0] a;
      a        = (k == 0) ? 6'd19 : (k == 1) ? 6'd21 : 6'd63;
      exp_word = (k == 0) ? 4'b0011 : 4'b1000;
      applyStimulus(1'b0, 6'd0, 4'h0, 1'b1, a, 1'b0, 4'h0);
      applyStimulus(1'b0, 6'd0, 4'h0, 1'b0, 6'd0, 1'b0, 4'h0);
      #2;
      checkOutput("lit abort readback", 32'(scan_rdata), 32'(exp_word));
    end

    // Randomized traffic; requests are held until granted.
    repeat (600) begin
      pen_taken  = pen_gnt;
      scan_taken = scan_gnt;
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 199) != 0);
      if (!pen_req || pen_taken) begin
        pen_req  = ($urandom_range(0, 2) != 0);
        pen_addr = 6'($urandom_range(0, 63));
        pen_data = 4'($urandom_range(0, 15));
      end
      if (!scan_req || scan_taken) begin
        scan_req  = ($urandom_range(0, 2) != 0);
        scan_addr = 6'($urandom_range(0, 63));
      end
      clr_start = ($urandom_range(0, 59) == 0);
      clr_data  = 4'($urandom_range(0, 15));
      #2;
    end
    applyStimulus(1'b0, 6'd0, 4'h0, 1'b0, 6'd0, 1'b0, 4'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
